// File: rtl/inst_rom_loader.sv
// Instruction ROM for the CPU fetch port. A zero-latency read path serves fetches, and a
// byte-stream loader fills the memory big-endian while it holds the CPU in reset.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  addr_err_o,
  input  logic                  load_start_i,
  input  logic                  load_byte_valid_i,
  input  logic [7:0]            load_byte_i,
  output logic                  load_byte_ready_o,
  input  logic                  load_done_i,
  output logic                  loading_o,
  output logic [ADDR_WIDTH:0]   load_words_o,
  output logic                  overflow_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FullPtr = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PtrOne  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

  state_e              state_q, state_d;
  logic                loading_q;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_WIDTH:0] load_words_q, load_words_d;
  logic                overflow_q, overflow_d;

  logic [31:0]         mem [DEPTH];

  logic                byte_ready;
  logic                byte_accept;
  logic [1:0]          cnt_after;
  logic                mem_we;
  logic [31:0]         mem_wdata;

  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;

  // State and datapath registers; reset aborts a load but leaves memory contents alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      loading_q    <= 1'b0;
      wr_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      load_words_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Registered so the CPU reset line sees a glitch-free level.
      loading_q    <= (state_d != StIdle);
      wr_ptr_q     <= wr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      load_words_q <= load_words_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state logic; a start pulse in any state (re)enters LOAD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_start_i) state_d = StLoad;
      end
      StLoad: begin
        if (load_start_i) begin
          state_d = StLoad;
        end else if (load_done_i) begin
          // Done sees the byte count after any byte accepted in the same cycle.
          state_d = (cnt_after == 2'd0) ? StIdle : StFlush;
        end
      end
      StFlush: begin
        state_d = load_start_i ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath next values: byte handshake, big-endian assembly, memory writes.
  always_comb begin
    byte_ready   = (state_q == StLoad) && (wr_ptr_q < FullPtr);
    byte_accept  = load_byte_valid_i && byte_ready;
    cnt_after    = byte_cnt_q + {1'b0, byte_accept};

    wr_ptr_d     = wr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    load_words_d = load_words_q;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;
    mem_wdata    = word_q;

    if (load_start_i) begin
      wr_ptr_d     = '0;
      byte_cnt_d   = '0;
      word_d       = '0;
      load_words_d = '0;
      overflow_d   = 1'b0;
    end else if (state_q == StLoad) begin
      if (byte_accept) begin
        if (byte_cnt_q == 2'd3) begin
          mem_we       = 1'b1;
          mem_wdata    = {word_q[31:8], load_byte_i};
          wr_ptr_d     = wr_ptr_q + PtrOne;
          load_words_d = load_words_q + PtrOne;
          byte_cnt_d   = '0;
          word_d       = '0;
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0:    word_d[31:24] = load_byte_i;
            2'd1:    word_d[23:16] = load_byte_i;
            2'd2:    word_d[15:8]  = load_byte_i;
            default: word_d        = word_q;
          endcase
        end
      end
      // In LOAD the only reason for ready=0 is a full memory.
      if (load_byte_valid_i && !byte_ready) overflow_d = 1'b1;
    end else if (state_q == StFlush) begin
      // Unfilled low bytes of word_q are already zero.
      mem_we       = 1'b1;
      mem_wdata    = word_q;
      wr_ptr_d     = wr_ptr_q + PtrOne;
      load_words_d = load_words_q + PtrOne;
      byte_cnt_d   = '0;
      word_d       = '0;
    end

    if (rst) mem_we = 1'b0;

    load_byte_ready_o = byte_ready;
    loading_o         = loading_q;
    load_words_o      = load_words_q;
    overflow_o        = overflow_q;
  end

  // Memory write port, no reset so a program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= mem_wdata;
  end

  // Zero-latency fetch; data is forced to zero while loading so no read/write overlap occurs.
  always_comb begin
    widx       = rom_addr_i[ADDR_WIDTH+1:2];
    in_range   = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
    rom_data_o = (rom_ce_i && !loading_q && in_range) ? mem[widx] : 32'h0;
    addr_err_o = rom_ce_i && ((rom_addr_i[1:0] != 2'b00) || !in_range);
  end

endmodule
